bitcount_result_buffer: RTL and testbench
=========================================

# bitcount_result_buffer

Downstream stage of the bit-counter datapath. Captures each 5-bit popcount `result` when the bit-counter controller pulses `done`, and queues it in a small first-word-fall-through FIFO. Drains the queue to a consumer over a valid/ready handshake, such as the HEX display driver or a result-logging stage. Optionally keeps a saturating running total of all accepted popcounts.

## Interface
- `DEPTH`, default 4: number of FIFO entries; power of two, ≥2.
- `clk`: input, 1 bit, system clock; all state changes on the rising edge.
- `reset`: input, 1 bit, asynchronous, active-low reset; 0 forces the reset state immediately.
- `done`: input, 1 bit, single-cycle pulse from the bit-counter controller; `result` is valid in the same cycle.
- `result`: input, 5 bits, popcount from the bit-counter datapath, range 0–8.
- `clear`: input, 1 bit, synchronous flush of FIFO, `drop` and `total`.
- `out_ready`: input, 1 bit, consumer accepts the head entry.
- `out_valid`: output, 1 bit, FIFO non-empty.
- `out_data`: output, 5 bits, head entry.
- `count`: output, log2(DEPTH)+1 bits, current occupancy, 0..DEPTH.
- `full`: output, 1 bit, high when `count == DEPTH`.
- `drop`: output, 1 bit, sticky flag: a `done` pulse was lost.
- `total`: output, 11 bits, running sum of accepted results (present only with `BITCOUNT_TOTAL_EN`).

## Operation
- **Storage:** DEPTH×5 register array, read pointer, write pointer, occupancy counter. Pointers wrap modulo DEPTH.
- **Push:**
  - `push = done & (~full | pop)`.
  - On push, write `result` at the write pointer and advance it.
- **Pop:**
  - `pop = out_valid & out_ready`; advances the read pointer.
  - `out_ready` while empty has no effect.
- **Occupancy:**
  - `count` increments on push only, decrements on pop only, and is unchanged on push+pop or neither.
- **Overflow:**
  - `done` while full with no pop discards `result`.
  - The discarded push sets `drop`.
  - `drop` stays set until `clear` or reset.
- **Head output:**
  - `out_data` = entry at the read pointer (combinational read).
  - `out_data` holds its last value when empty; consumers must ignore it when `out_valid` = 0.
- **Handshake rule:**
  - While `out_valid` = 1 and not popped, `out_data` must not change.
  - Pushes never disturb the head entry.
- **Clear:**
  - Next edge: pointers, `count`, `drop` and `total` go to 0.
  - `clear` overrides any simultaneous push or pop; that `done` is neither stored nor counted as a drop.
- **Out-of-range input:** `result` values >8 are stored as given; no checking.

## Timing
- **Reset values:**
  - `out_valid`=0, `count`=0, `full`=0, `drop`=0, `total`=0.
  - `out_data` is 0 after reset (array cleared).
- **Latency:**
  - `done` sampled at edge k into an empty FIFO gives `out_valid`=1 and `out_data`=`result` after edge k.
  - One cycle, no bubble.
- **Throughput:** one push and one pop per cycle sustained; back-to-back `done` pulses are accepted every cycle while not full.
- **Full boundary:** `full` asserts in the cycle after the DEPTH-th push; a push+pop when full keeps `count`=DEPTH.
- **Empty boundary:** pop of the last entry deasserts `out_valid` after that edge; push into empty with `out_ready`=1 gives no same-cycle pass-through.
- **Reset mid-operation:** asynchronous; all contents are lost and outputs go to reset values immediately.

## Configuration
- Macro: `BITCOUNT_TOTAL_EN`.
- **Defined:**
  - 11-bit `total` port exists; each accepted push adds `result`.
  - `total` saturates at 2047; further pushes leave it at 2047.
  - Dropped results are not added.
  - `clear` and reset zero it.
- **Undefined:** the `total` port and its adder/register are absent; all other behaviour is identical.

## Test plan
- **Reset and single push:** reset low then high; `done`=1 with `result`=5, `out_ready`=0 → next cycle `out_valid`=1, `out_data`=5, `count`=1.
- **Ordering:** push 3,7,0,8 with `out_ready`=0 → `full`=1, `count`=4; then hold `out_ready`=1 → `out_data` 3,7,0,8 on successive cycles, then `out_valid`=0.
- **Overflow:** fill with 4 pushes, then `done` with `result`=6 and `out_ready`=0 → `drop`=1, `count`=4, and 6 never appears.
- **Simultaneous push+pop when full:** `done` with `result`=2 and `out_ready`=1 → `count` stays 4, `drop` stays 0, and 2 emerges fourth.
- **Clear and reset priority:**
  - `clear`=1 with `done`=1 → next cycle `count`=0, `drop`=0, `total`=0.
  - Assert `reset`=0 mid-burst between edges → outputs zero immediately.
- **Total saturation (`BITCOUNT_TOTAL_EN`):** 256 pushes of 8 with `out_ready`=1 → `total`=2047 (not 2048), held on further pushes.

Source files
------------

// File: rtl/bitcount_result_buffer_if.sv
// Output stream of the bit-count result buffer: head entry offered over valid/ready.
// The buffer drives the master side and the consumer takes the slave side.
interface bitcount_result_buffer_if;
    logic       out_valid;
    logic [4:0] out_data;
    logic       out_ready;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/bitcount_result_buffer.sv
// First-word-fall-through queue of 5-bit popcount results, with a sticky overflow flag.
// Optional macro BITCOUNT_TOTAL_EN adds an 11-bit saturating running total of accepted results.
module bitcount_result_buffer #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     done,
    input  logic [4:0]               result,
    input  logic                     clear,
    bitcount_result_buffer_if.master out_if,
    output logic [CW-1:0]            count,
    output logic                     full,
`ifdef BITCOUNT_TOTAL_EN
    output logic                     drop,
    output logic [10:0]              total
`else
    output logic                     drop
`endif
);

    logic [4:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_next_s;
    logic          valid_r;
    logic          full_r;
    logic          drop_r;
    logic          push_s;
    logic          pop_s;

    // A push while full is only legal when the head leaves in the same cycle.
    assign pop_s  = valid_r & out_if.out_ready;
    assign push_s = done & (~full_r | pop_s);

    // Next occupancy from the push/pop pair.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Pointers, occupancy, status flags; clear flushes without touching storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            valid_r  <= 1'b0;
            full_r   <= 1'b0;
            drop_r   <= 1'b0;
        end else if (clear) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            valid_r  <= 1'b0;
            full_r   <= 1'b0;
            drop_r   <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            if (done && !push_s) begin
                drop_r <= 1'b1;
            end
            count_r <= count_next_s;
            valid_r <= (count_next_s != {CW{1'b0}});
            full_r  <= (count_next_s == CW'(DEPTH));
        end
    end

    // Storage array; reset zeroes it so the head reads 0 afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 5'd0;
            end
        end else if (!clear && push_s) begin
            mem_r[wr_ptr_r] <= result;
        end
    end

    assign out_if.out_valid = valid_r;
    assign out_if.out_data  = mem_r[rd_ptr_r];
    assign count            = count_r;
    assign full             = full_r;
    assign drop             = drop_r;

`ifdef BITCOUNT_TOTAL_EN
    logic [10:0] total_r;
    logic [11:0] total_sum_s;
    logic [10:0] total_next_s;

    // Saturating add of the accepted result.
    always_comb begin
        total_sum_s = {1'b0, total_r} + {7'd0, result};
        if (total_sum_s[11]) begin
            total_next_s = 11'h7FF;
        end else begin
            total_next_s = total_sum_s[10:0];
        end
    end

    // Running total register; dropped results never reach it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            total_r <= 11'd0;
        end else if (clear) begin
            total_r <= 11'd0;
        end else if (push_s) begin
            total_r <= total_next_s;
        end
    end

    assign total = total_r;
`endif

endmodule

// File: tb/tb_bitcount_result_buffer.sv
// Directed self-checking bench for bitcount_result_buffer (DEPTH=4).
module tb_bitcount_result_buffer;
    logic       clk;
    logic       reset;
    logic       done;
    logic [4:0] result;
    logic       clear;
    logic [2:0] count;
    logic       full;
    logic       drop;
`ifdef BITCOUNT_TOTAL_EN
    logic [10:0] total;
`endif
    int check_cnt = 0;
    int pass_cnt  = 0;

    bitcount_result_buffer_if bif ();

    bitcount_result_buffer #(.DEPTH(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .done   (done),
        .result (result),
        .clear  (clear),
        .out_if (bif.master),
        .count  (count),
        .full   (full),
`ifdef BITCOUNT_TOTAL_EN
        .drop   (drop),
        .total  (total)
`else
        .drop   (drop)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] v);
        done = 1'b1; result = v;
        step();
        done = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; done = 1'b0; result = 5'd0; clear = 1'b0; bif.out_ready = 1'b0;
        #13;
        check_cnt++; if (bif.out_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", bif.out_valid); else pass_cnt++;
        check_cnt++; if (count !== 3'd0) $display("FAIL reset_count got %0d want 0", count); else pass_cnt++;
        check_cnt++; if (full !== 1'b0) $display("FAIL reset_full got %0b want 0", full); else pass_cnt++;
        check_cnt++; if (drop !== 1'b0) $display("FAIL reset_drop got %0b want 0", drop); else pass_cnt++;
        check_cnt++; if (bif.out_data !== 5'd0) $display("FAIL reset_data got %0d want 0", bif.out_data); else pass_cnt++;
        @(negedge clk); reset = 1'b1;
        step();
    endtask

    task automatic test_single_push();
        push(5'd5);
        check_cnt++; if (bif.out_valid !== 1'b1) $display("FAIL single_valid got %0b want 1", bif.out_valid); else pass_cnt++;
        check_cnt++; if (bif.out_data !== 5'd5) $display("FAIL single_data got %0d want 5", bif.out_data); else pass_cnt++;
        check_cnt++; if (count !== 3'd1) $display("FAIL single_count got %0d want 1", count); else pass_cnt++;
        bif.out_ready = 1'b1; step(); bif.out_ready = 1'b0;
        check_cnt++; if (bif.out_valid !== 1'b0) $display("FAIL single_drain_valid got %0b want 0", bif.out_valid); else pass_cnt++;
        check_cnt++; if (count !== 3'd0) $display("FAIL single_drain_count got %0d want 0", count); else pass_cnt++;
    endtask

    task automatic test_ordering();
        logic [4:0] exp [4] = '{5'd3, 5'd7, 5'd0, 5'd8};
        for (int i = 0; i < 4; i++) push(exp[i]);
        check_cnt++; if (full !== 1'b1) $display("FAIL order_full got %0b want 1", full); else pass_cnt++;
        check_cnt++; if (count !== 3'd4) $display("FAIL order_count got %0d want 4", count); else pass_cnt++;
        bif.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_cnt++; if (bif.out_data !== exp[i] || bif.out_valid !== 1'b1)
                $display("FAIL order_data[%0d] got %0d/v%0b want %0d/v1", i, bif.out_data, bif.out_valid, exp[i]); else pass_cnt++;
            step();
        end
        bif.out_ready = 1'b0;
        check_cnt++; if (bif.out_valid !== 1'b0) $display("FAIL order_empty got %0b want 0", bif.out_valid); else pass_cnt++;
    endtask

    task automatic test_overflow();
        logic [4:0] exp [4] = '{5'd1, 5'd2, 5'd3, 5'd4};
        for (int i = 0; i < 4; i++) push(exp[i]);
        push(5'd6);
        check_cnt++; if (drop !== 1'b1) $display("FAIL ovf_drop got %0b want 1", drop); else pass_cnt++;
        check_cnt++; if (count !== 3'd4) $display("FAIL ovf_count got %0d want 4", count); else pass_cnt++;
        step();
        check_cnt++; if (drop !== 1'b1) $display("FAIL ovf_drop_sticky got %0b want 1", drop); else pass_cnt++;
        bif.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_cnt++; if (bif.out_data !== exp[i]) $display("FAIL ovf_data[%0d] got %0d want %0d", i, bif.out_data, exp[i]); else pass_cnt++;
            step();
        end
        bif.out_ready = 1'b0;
        check_cnt++; if (bif.out_valid !== 1'b0 || count !== 3'd0) $display("FAIL ovf_empty got v%0b c%0d want v0 c0", bif.out_valid, count); else pass_cnt++;
        clear = 1'b1; step(); clear = 1'b0;
        check_cnt++; if (drop !== 1'b0) $display("FAIL ovf_clear_drop got %0b want 0", drop); else pass_cnt++;
    endtask

    task automatic test_push_pop_full();
        logic [4:0] exp [4] = '{5'd10, 5'd11, 5'd12, 5'd2};
        push(5'd9); push(5'd10); push(5'd11); push(5'd12);
        done = 1'b1; result = 5'd2; bif.out_ready = 1'b1;
        step();
        done = 1'b0;
        check_cnt++; if (count !== 3'd4 || full !== 1'b1) $display("FAIL pp_count got c%0d f%0b want c4 f1", count, full); else pass_cnt++;
        check_cnt++; if (drop !== 1'b0) $display("FAIL pp_drop got %0b want 0", drop); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            check_cnt++; if (bif.out_data !== exp[i] || bif.out_valid !== 1'b1)
                $display("FAIL pp_data[%0d] got %0d/v%0b want %0d/v1", i, bif.out_data, bif.out_valid, exp[i]); else pass_cnt++;
            step();
        end
        bif.out_ready = 1'b0;
        check_cnt++; if (bif.out_valid !== 1'b0) $display("FAIL pp_empty got %0b want 0", bif.out_valid); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        bif.out_ready = 1'b1;
        step();
        check_cnt++; if (count !== 3'd0 || bif.out_valid !== 1'b0) $display("FAIL b2b_idle got c%0d v%0b want c0 v0", count, bif.out_valid); else pass_cnt++;
        done = 1'b1; result = 5'd7;
        step();
        check_cnt++; if (bif.out_valid !== 1'b1 || bif.out_data !== 5'd7 || count !== 3'd1)
            $display("FAIL b2b_first got v%0b d%0d c%0d want v1 d7 c1", bif.out_valid, bif.out_data, count); else pass_cnt++;
        result = 5'd1;
        step();
        check_cnt++; if (bif.out_data !== 5'd1 || count !== 3'd1) $display("FAIL b2b_second got d%0d c%0d want d1 c1", bif.out_data, count); else pass_cnt++;
        done = 1'b0;
        step();
        bif.out_ready = 1'b0;
        check_cnt++; if (bif.out_valid !== 1'b0) $display("FAIL b2b_empty got %0b want 0", bif.out_valid); else pass_cnt++;
    endtask

    task automatic test_clear();
        push(5'd1); push(5'd2); push(5'd3); push(5'd4); push(5'd5);
        check_cnt++; if (drop !== 1'b1) $display("FAIL clr_pre_drop got %0b want 1", drop); else pass_cnt++;
        clear = 1'b1; done = 1'b1; result = 5'd5; bif.out_ready = 1'b1;
        step();
        clear = 1'b0; done = 1'b0; bif.out_ready = 1'b0;
        check_cnt++; if (count !== 3'd0 || bif.out_valid !== 1'b0 || full !== 1'b0)
            $display("FAIL clr_state got c%0d v%0b f%0b want c0 v0 f0", count, bif.out_valid, full); else pass_cnt++;
        check_cnt++; if (drop !== 1'b0) $display("FAIL clr_drop got %0b want 0", drop); else pass_cnt++;
`ifdef BITCOUNT_TOTAL_EN
        check_cnt++; if (total !== 11'd0) $display("FAIL clr_total got %0d want 0", total); else pass_cnt++;
`endif
    endtask

    task automatic test_async_reset();
        push(5'd21); push(5'd22); push(5'd23); push(5'd24);
        done = 1'b1; result = 5'd25;
        step();
        #2 reset = 1'b0;
        #1;
        check_cnt++; if (bif.out_valid !== 1'b0 || count !== 3'd0 || full !== 1'b0 || drop !== 1'b0 || bif.out_data !== 5'd0)
            $display("FAIL areset got v%0b c%0d f%0b dr%0b d%0d want all 0", bif.out_valid, count, full, drop, bif.out_data); else pass_cnt++;
        done = 1'b0;
        @(negedge clk); reset = 1'b1;
        step();
    endtask

`ifdef BITCOUNT_TOTAL_EN
    task automatic test_total();
        push(5'd1); push(5'd1); push(5'd1); push(5'd1); push(5'd8);
        check_cnt++; if (total !== 11'd4) $display("FAIL tot_drop got %0d want 4", total); else pass_cnt++;
        clear = 1'b1; step(); clear = 1'b0;
        bif.out_ready = 1'b1; done = 1'b1; result = 5'd8;
        for (int i = 0; i < 255; i++) step();
        check_cnt++; if (total !== 11'd2040) $display("FAIL tot_255 got %0d want 2040", total); else pass_cnt++;
        step();
        check_cnt++; if (total !== 11'd2047) $display("FAIL tot_sat got %0d want 2047", total); else pass_cnt++;
        step(); step();
        check_cnt++; if (total !== 11'd2047) $display("FAIL tot_hold got %0d want 2047", total); else pass_cnt++;
        done = 1'b0; step(); bif.out_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_push();
        test_ordering();
        test_overflow();
        test_push_pop_full();
        test_back_to_back();
        test_clear();
        test_async_reset();
`ifdef BITCOUNT_TOTAL_EN
        test_total();
`endif
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
